// File: rtl/prio_aging_fifo.sv
// Per-channel ingress FIFO feeding one arbiter input; the head entry's priority
// is boosted the longer it stalls so low-priority sources cannot be starved.
module prio_aging_fifo #(
  parameter int DATA_W   = 32,
  parameter int PRIO_W   = 3,
  parameter int DEPTH    = 4,
  parameter int AGE_STEP = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [PRIO_W-1:0]        in_prio,
  output logic                     in_ready,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [PRIO_W-1:0]        prioity_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(AGE_STEP) + 1;
  localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);
  localparam logic [TW-1:0]     TMR_LOAD  = TW'(AGE_STEP - 1);
  localparam logic [PRIO_W-1:0] BOOST_MAX = {PRIO_W{1'b1}};

  logic [DATA_W+PRIO_W-1:0] mem [DEPTH];
  logic [AW-1:0]            rd_ptr;
  logic [AW-1:0]            wr_ptr;
  logic [CW-1:0]            count;
  logic [TW-1:0]            age_tmr;
  logic [PRIO_W-1:0]        boost;

  logic              push;
  logic              pop;
  logic              stalled;
  logic [PRIO_W-1:0] head_prio;
  logic [PRIO_W:0]   prio_sum;

  assign in_ready = (count != FULL_CNT);
  assign valid_o  = (count != '0);
  assign count_o  = count;
  assign push     = in_valid && in_ready;
  assign pop      = valid_o && ready_i;
  assign stalled  = valid_o && !ready_i;

  assign data_o    = mem[rd_ptr][DATA_W+PRIO_W-1:PRIO_W];
  assign head_prio = mem[rd_ptr][PRIO_W-1:0];
  assign prio_sum  = {1'b0, head_prio} + {1'b0, boost};

  always_comb begin
    prioity_o = '0;
    if (valid_o) begin
      prioity_o = prio_sum[PRIO_W] ? BOOST_MAX : prio_sum[PRIO_W-1:0];
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= {in_data, in_prio};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Aging timer counts down stall cycles; each terminal count adds one boost step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      age_tmr <= TMR_LOAD;
      boost   <= '0;
    end else if (pop || !valid_o) begin
      age_tmr <= TMR_LOAD;
      boost   <= '0;
    end else if (stalled) begin
      if (age_tmr == '0) begin
        age_tmr <= TMR_LOAD;
        if (boost != BOOST_MAX) boost <= boost + PRIO_W'(1);
      end else begin
        age_tmr <= age_tmr - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prio_aging_fifo.sv
// Directed bench for prio_aging_fifo: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the directed sequence.
module tb_prio_aging_fifo;

  localparam int DATA_W   = 32;
  localparam int PRIO_W   = 3;
  localparam int DEPTH    = 4;
  localparam int AGE_STEP = 8;
  localparam int PMAX     = (1 << PRIO_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [PRIO_W-1:0] in_prio;
  logic              in_ready;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic [PRIO_W-1:0] prioity_o;
  logic              ready_i;
  logic [2:0]        count_o;

  int n_checks = 0;
  int n_fail   = 0;

  prio_aging_fifo #(
    .DATA_W(DATA_W), .PRIO_W(PRIO_W), .DEPTH(DEPTH), .AGE_STEP(AGE_STEP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_prio(in_prio), .in_ready(in_ready),
    .valid_o(valid_o), .data_o(data_o), .prioity_o(prioity_o), .ready_i(ready_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {data, prio} and number of stall cycles of the current head.
  logic [DATA_W+PRIO_W-1:0] q[$];
  int  stall_cycles = 0;
  bit  model_live   = 1'b0;

  always @(posedge clk) begin
    bit m_push, m_pop;
    if (!reset_n) begin
      q.delete();
      stall_cycles = 0;
      model_live   = 1'b1;
    end else if (model_live) begin
      m_push = in_valid && (q.size() != DEPTH);
      m_pop  = (q.size() != 0) && ready_i;
      if (m_pop) begin
        void'(q.pop_front());
        stall_cycles = 0;
      end else if (q.size() != 0) begin
        stall_cycles++;
      end
      if (m_push) q.push_back({in_data, in_prio});
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int boost, eprio;
    if (model_live) begin
      chk("model in_ready", in_ready, (q.size() != DEPTH));
      chk("model valid_o",  valid_o,  (q.size() != 0));
      chk("model count_o",  count_o,  q.size());
      if (q.size() != 0) begin
        boost = stall_cycles / AGE_STEP;
        if (boost > PMAX) boost = PMAX;
        eprio = int'(q[0][PRIO_W-1:0]) + boost;
        if (eprio > PMAX) eprio = PMAX;
        chk("model data_o",    data_o,    q[0][DATA_W+PRIO_W-1:PRIO_W]);
        chk("model prioity_o", prioity_o, eprio);
      end else begin
        chk("model prioity_o idle", prioity_o, 0);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_one(input logic [DATA_W-1:0] d, input logic [PRIO_W-1:0] p);
    in_valid = 1'b1; in_data = d; in_prio = p;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    ready_i = 1'b1;
    for (int k = 0; k < 2*DEPTH && valid_o; k++) step();
    ready_i = 1'b0;
    chk("drain empty", valid_o, 0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_prio = '0; ready_i = 1'b0;
    step(2);
    reset_n = 1'b1;
    step();
    chk("reset in_ready",  in_ready,  1);
    chk("reset valid_o",   valid_o,   0);
    chk("reset count_o",   count_o,   0);
    chk("reset prioity_o", prioity_o, 0);

    for (int i = 0; i < 4; i++) push_one(32'hA0 + i, 3'd1);
    chk("full count", count_o, 4);
    chk("full in_ready", in_ready, 0);
    push_one(32'hA4, 3'd1);
    chk("full refuse count", count_o, 4);

    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain order", data_o, 32'hA0 + i);
      step();
    end
    ready_i = 1'b0;
    chk("drained valid", valid_o, 0);
    chk("drained count", count_o, 0);

    for (int i = 0; i < 3; i++) push_one(32'hD0 + i, 3'd0);
    chk("pre-reset count", count_o, 3);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid reset count", count_o, 0);
    chk("mid reset valid", valid_o, 0);

    push_one(32'h55, 3'd2);
    chk("age start", prioity_o, 2);
    step(7);
    chk("age 7", prioity_o, 2);
    step(1);
    chk("age 8", prioity_o, 3);
    step(8);
    chk("age 16", prioity_o, 4);
    drain();

    push_one(32'h66, 3'd6);
    step(8);
    chk("sat 8", prioity_o, 7);
    step(32);
    chk("sat 40", prioity_o, 7);
    drain();

    push_one(32'hB0, 3'd0);
    push_one(32'hB1, 3'd0);
    step(15);
    chk("boost 16", prioity_o, 2);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("boost cleared", prioity_o, 0);
    chk("next head", data_o, 32'hB1);
    drain();

    push_one(32'hC0, 3'd3);
    push_one(32'hC1, 3'd4);
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stream data", data_o, 32'hC0 + i);
      chk("stream count", count_o, 2);
      in_valid = 1'b1; in_data = 32'hC2 + i; in_prio = 3'(i);
      step();
    end
    in_valid = 1'b0;
    chk("stream tail0", data_o, 32'hCA);
    step();
    chk("stream tail1", data_o, 32'hCB);
    step();
    ready_i = 1'b0;
    chk("stream empty", valid_o, 0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_aging_fifo.md
Name: prio_aging_fifo

Overview:
- Per-channel ingress buffer placed directly upstream of each channel input of the 8-channel priority arbiter.
- One instance per channel: it absorbs bursts from the source in a small FIFO and presents the head entry to the arbiter as a valid/data/priority/ready stream.
- The priority it presents for the head entry rises the longer that entry waits (priority aging), so low-priority channels cannot be starved by the arbiter.

Parameters:
- DATA_W, 32, payload width.
- PRIO_W, 3, priority width; a larger value means higher priority.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AGE_STEP, 8, stall cycles per +1 priority boost; at least 1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  source has a beat.
- in_data  in  DATA_W  source payload.
- in_prio  in  PRIO_W  source priority of the beat.
- in_ready  out  1  FIFO can accept a beat.
- valid_o  out  1  head entry available; connects to arbiter valid_i_N.
- data_o  out  DATA_W  head payload; connects to arbiter data_i_N.
- prioity_o  out  PRIO_W  aged head priority; connects to arbiter prioity_i_N.
- ready_i  in  1  arbiter accepts the head; driven by arbiter ready_i_N.
- count_o  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - When reset_n=0 at an edge: rd_ptr=0, wr_ptr=0, count=0, age_cnt=0, boost=0.
  - Storage contents are not reset.
  - Output values during and after reset: in_ready=1, valid_o=0, count_o=0, prioity_o=0, data_o=don't-care.
  - Reset asserted mid-operation discards all buffered entries; no beat is popped or pushed on that edge.
- Push: occurs when in_valid && in_ready. Writes {in_data, in_prio} at wr_ptr, then wr_ptr++ (wraps modulo DEPTH).
- Pop: occurs when valid_o && ready_i. Advances rd_ptr (wraps modulo DEPTH).
- Combinational status:
  - in_ready = (count != DEPTH). No full-bypass: when full, a push is refused even if a pop happens in the same cycle.
  - valid_o = (count != 0). No empty-bypass: a beat pushed at edge N is first visible on valid_o after edge N, so latency is 1 cycle minimum.
- Occupancy:
  - count updates +1 on push only, -1 on pop only, unchanged on both or neither.
  - count_o = count.
- Output data: data_o is taken directly from the storage entry at rd_ptr.
- Aging:
  - Waiting condition: valid_o && !ready_i.
  - While waiting, age_cnt increments every cycle.
  - When age_cnt == AGE_STEP-1 while waiting: age_cnt <= 0, and boost <= boost+1, saturating at 2^PW-1.
  - On pop: age_cnt <= 0 and boost <= 0, so the new head starts un-aged.
  - When empty: age_cnt and boost are held at 0.
- Output priority: prioity_o = min(head_prio + boost, 2^PW-1), computed at PRIO_W+1 bits and then saturated.
- Handshake rules:
  - Once valid_o=1, it and data_o remain stable until a pop.
  - prioity_o may only rise while valid_o is held. The arbiter tolerates this.
  - in_ready does not depend on in_valid.
- Simultaneous push and pop with 0<count<DEPTH: both take effect and count is unchanged. Order is preserved (strict FIFO).
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer compare.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n=0 for 2 cycles, then release.
  - Required: in_ready=1, valid_o=0, count_o=0, prioity_o=0.
  - Stimulus: drive reset_n=0 again with 3 entries buffered.
  - Required: count_o=0 and valid_o=0 after the edge.
- Fill and full:
  - Stimulus: ready_i=0; push 0xA0..0xA3 with prio 1 on 4 consecutive cycles.
  - Required: count_o=4, in_ready=0. A 5th beat 0xA4 is not accepted and count stays 4.
- Drain order:
  - Stimulus: starting full as above, set ready_i=1.
  - Required: data_o shows 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, then valid_o=0, count_o=0.
- Aging:
  - Stimulus: push one beat with prio 2, hold ready_i=0.
  - Required: prioity_o=2 for the first 8 stalled cycles, 3 after 8, 4 after 16.
  - Required: with prio 6, prioity_o saturates at 7 after 8 cycles and stays 7 after 40.
- Boost reset on pop:
  - Stimulus: two beats prio 0; stall 16 cycles so prioity_o=2, then ready_i=1 for one cycle.
  - Required: next head shows prioity_o=0 the following cycle.
- Concurrent push/pop and wrap:
  - Stimulus: count=2; push and pop every cycle for 10 cycles with ready_i=1, in_valid=1.
  - Required: count_o stays 2, pointers wrap past DEPTH, and output sequence equals input sequence delayed by 2 beats.
